// File: rtl/md_sequencer.sv
// ---------------------------------------------------------------------------
// md_sequencer
//
// Iterative signed multiply / divide sequencer. An accepted operation runs
// one bit per clock for WIDTH cycles, then spends a single FINISH cycle in
// which done and hilo_write pulse and hi/lo present the new result. A divide
// by zero skips the iteration and pulses done/div0 in a single ZERO cycle,
// leaving hi/lo untouched.
//
// Ports
//   clock      in   system clock, rising-edge active
//   reset      in   synchronous active-high reset
//   start      in   begin an operation (only honoured in IDLE)
//   op         in   0 = signed multiply, 1 = signed divide
//   a, b       in   multiplicand/multiplier or dividend/divisor
//   busy       out  operation in progress (iteration + FINISH/ZERO cycle)
//   done       out  one-cycle completion pulse
//   hilo_write out  one-cycle pulse when hi/lo take a new result
//   div0       out  one-cycle pulse for a divide with b == 0
//   hi, lo     out  product high/low halves, or remainder/quotient
// ---------------------------------------------------------------------------
module md_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             hilo_write,
    output logic             div0,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int                 CNT_W    = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        MULT,
        DIV,
        FINISH,
        ZERO
    } state_t;

    state_t             state_q,      state_d;
    logic [CNT_W-1:0]   cnt_q,        cnt_d;
    logic [2*WIDTH-1:0] acc_q,        acc_d;
    logic [WIDTH-1:0]   opnd_q,       opnd_d;
    logic               sign_a_q,     sign_a_d;
    logic               sign_b_q,     sign_b_d;
    logic               busy_q,       busy_d;
    logic               done_q,       done_d;
    logic               hilo_write_q, hilo_write_d;
    logic               div0_q,       div0_d;
    logic [WIDTH-1:0]   hi_q,         hi_d;
    logic [WIDTH-1:0]   lo_q,         lo_d;

    // Operand magnitudes. The most negative value maps onto itself, which is
    // the correct unsigned magnitude 2^(WIDTH-1).
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    // Multiply datapath: acc holds {partial product, remaining multiplier}.
    // The multiplier bit in acc[0] decides whether the multiplicand is added
    // to the upper half before the whole accumulator shifts right.
    logic [WIDTH:0]     mult_sum;
    logic [2*WIDTH-1:0] mult_next;
    logic [2*WIDTH-1:0] mult_signed;

    // Divide datapath: acc holds {partial remainder, dividend/quotient}.
    // The dividend MSB shifts into the remainder and the quotient bit shifts
    // into the freed LSB, so after WIDTH steps the low half is the quotient.
    logic [WIDTH:0]     div_shift;
    logic               div_fits;
    logic [WIDTH-1:0]   div_diff;
    logic [2*WIDTH-1:0] div_next;
    logic [WIDTH-1:0]   quot_signed;
    logic [WIDTH-1:0]   rem_signed;

    // Datapath for one iteration step, plus sign fix-up of the final value
    // so it can be latched into hi/lo on the same edge that enters FINISH.
    always_comb begin
        a_mag       = a[WIDTH-1] ? -a : a;
        b_mag       = b[WIDTH-1] ? -b : b;

        mult_sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                    + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mult_next   = {mult_sum, acc_q[WIDTH-1:1]};
        mult_signed = (sign_a_q ^ sign_b_q) ? -mult_next : mult_next;

        div_shift   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_fits    = (div_shift >= {1'b0, opnd_q});
        div_diff    = div_shift[WIDTH-1:0] - opnd_q;
        div_next    = div_fits ? {div_diff, acc_q[WIDTH-2:0], 1'b1}
                               : {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        quot_signed = (sign_a_q ^ sign_b_q) ? -div_next[WIDTH-1:0]
                                            : div_next[WIDTH-1:0];
        rem_signed  = sign_a_q ? -div_next[2*WIDTH-1:WIDTH]
                               : div_next[2*WIDTH-1:WIDTH];
    end

    // Next-state and next-output logic. All outputs are computed one cycle
    // ahead so they leave the block straight from flops.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        acc_d        = acc_q;
        opnd_d       = opnd_q;
        sign_a_d     = sign_a_q;
        sign_b_d     = sign_b_q;
        busy_d       = 1'b0;
        done_d       = 1'b0;
        hilo_write_d = 1'b0;
        div0_d       = 1'b0;
        hi_d         = hi_q;
        lo_d         = lo_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    sign_a_d = a[WIDTH-1];
                    sign_b_d = b[WIDTH-1];
                    cnt_d    = '0;
                    busy_d   = 1'b1;
                    if (!op) begin
                        state_d = MULT;
                        opnd_d  = a_mag;
                        acc_d   = {{WIDTH{1'b0}}, b_mag};
                    end else if (b == '0) begin
                        state_d = ZERO;
                        done_d  = 1'b1;
                        div0_d  = 1'b1;
                    end else begin
                        state_d = DIV;
                        opnd_d  = b_mag;
                        acc_d   = {{WIDTH{1'b0}}, a_mag};
                    end
                end
            end

            MULT: begin
                busy_d = 1'b1;
                acc_d  = mult_next;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d      = FINISH;
                    done_d       = 1'b1;
                    hilo_write_d = 1'b1;
                    hi_d         = mult_signed[2*WIDTH-1:WIDTH];
                    lo_d         = mult_signed[WIDTH-1:0];
                end
            end

            DIV: begin
                busy_d = 1'b1;
                acc_d  = div_next;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d      = FINISH;
                    done_d       = 1'b1;
                    hilo_write_d = 1'b1;
                    hi_d         = rem_signed;
                    lo_d         = quot_signed;
                end
            end

            // FINISH and ZERO are single-cycle; a start seen here is dropped.
            FINISH:  state_d = IDLE;
            ZERO:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with synchronous reset; reset wins over a
    // concurrent start and aborts any operation in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            acc_q        <= '0;
            opnd_q       <= '0;
            sign_a_q     <= 1'b0;
            sign_b_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            hilo_write_q <= 1'b0;
            div0_q       <= 1'b0;
            hi_q         <= '0;
            lo_q         <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            acc_q        <= acc_d;
            opnd_q       <= opnd_d;
            sign_a_q     <= sign_a_d;
            sign_b_q     <= sign_b_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            hilo_write_q <= hilo_write_d;
            div0_q       <= div0_d;
            hi_q         <= hi_d;
            lo_q         <= lo_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign hilo_write = hilo_write_q;
    assign div0       = div0_q;
    assign hi         = hi_q;
    assign lo         = lo_q;

endmodule

// File: tb/tb_md_sequencer.sv
// ---------------------------------------------------------------------------
// tb_md_sequencer
//
// Directed and randomised bench for md_sequencer at WIDTH = 32. Expected
// hi/lo values come from plain 64-bit signed arithmetic; cycle timing is
// followed by counting clock edges from the acceptance cycle.
// ---------------------------------------------------------------------------
module tb_md_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic        hilo_write;
    logic        div0;
    logic [31:0] hi;
    logic [31:0] lo;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;

    md_sequencer #(.WIDTH(32)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .op         (op),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .hilo_write (hilo_write),
        .div0       (div0),
        .hi         (hi),
        .lo         (lo)
    );

    always #5 clock = ~clock;

    // Advance one cycle; inputs are driven and outputs sampled 1 time unit
    // after the rising edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Present an operation in cycle 0, then scramble the operand inputs so
    // any later dependence on them shows up as a wrong result.
    task automatic applyStimulus(input logic o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        step();
        start = 1'b0;
        op    = 1'($urandom);
        a     = $urandom;
        b     = $urandom;
    endtask

    // Run one operation end to end. glitch_at != 0 pulses start with junk
    // operands in that cycle; poke_end pulses start in the FINISH/ZERO cycle.
    task automatic runOp(input logic o, input logic [31:0] x, input logic [31:0] y,
                         input int glitch_at, input bit poke_end);
        longint      sx;
        longint      sy;
        longint      p;
        logic [31:0] mh;
        logic [31:0] ml;
        bit          bad;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        mh = exp_hi;
        ml = exp_lo;
        if (!o) begin
            p  = sx * sy;
            mh = p[63:32];
            ml = p[31:0];
        end else if (y != 0) begin
            p  = sx / sy;
            ml = p[31:0];
            p  = sx % sy;
            mh = p[31:0];
        end

        applyStimulus(o, x, y);

        if (o && y == 0) begin
            checkOutput("zero_busy",  busy,       1);
            checkOutput("zero_done",  done,       1);
            checkOutput("zero_div0",  div0,       1);
            checkOutput("zero_hilo",  hilo_write, 0);
            checkOutput("zero_hi",    hi,         exp_hi);
            checkOutput("zero_lo",    lo,         exp_lo);
            if (poke_end) begin
                start = 1'b1; op = 1'b0; a = $urandom; b = $urandom;
            end
            step();
            start = 1'b0;
            checkOutput("zero_after_busy", busy, 0);
            checkOutput("zero_after_div0", div0, 0);
            return;
        end

        bad = 1'b0;
        for (int c = 1; c <= 32; c++) begin
            if (busy !== 1'b1 || done !== 1'b0 || hilo_write !== 1'b0 || div0 !== 1'b0)
                bad = 1'b1;
            if (c == glitch_at) begin
                start = 1'b1; op = 1'($urandom); a = $urandom; b = $urandom;
            end
            step();
            start = 1'b0;
            a     = $urandom;
            b     = $urandom;
        end

        checkOutput("iter_flags",  bad,        0);
        checkOutput("fin_busy",    busy,       1);
        checkOutput("fin_done",    done,       1);
        checkOutput("fin_hilo",    hilo_write, 1);
        checkOutput("fin_div0",    div0,       0);
        checkOutput("fin_hi",      hi,         mh);
        checkOutput("fin_lo",      lo,         ml);
        exp_hi = mh;
        exp_lo = ml;

        if (poke_end) begin
            start = 1'b1; op = 1'b0; a = $urandom; b = $urandom;
        end
        step();
        start = 1'b0;
        checkOutput("post_busy", busy, 0);
        checkOutput("post_done", done, 0);
        checkOutput("post_hi",   hi,   exp_hi);
        checkOutput("post_lo",   lo,   exp_lo);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        bit          bad;
        logic        ro;
        logic [31:0] ra;
        logic [31:0] rb;

        reset = 1'b1;
        start = 1'b0;
        op    = 1'b0;
        a     = '0;
        b     = '0;
        step();
        step();
        checkOutput("rst_busy", busy,       0);
        checkOutput("rst_done", done,       0);
        checkOutput("rst_hilo", hilo_write, 0);
        checkOutput("rst_div0", div0,       0);
        checkOutput("rst_hi",   hi,         0);
        checkOutput("rst_lo",   lo,         0);
        reset = 1'b0;
        step();

        // Directed values
        runOp(1'b0, 32'd7,         32'hFFFF_FFFD, 0, 1'b0);
        runOp(1'b0, 32'h8000_0000, 32'h8000_0000, 0, 1'b0);
        runOp(1'b1, 32'hFFFF_FFF9, 32'd2,         0, 1'b0);
        runOp(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
        runOp(1'b1, 32'd100,       32'd7,         0, 1'b0);
        runOp(1'b1, 32'd5,         32'd0,         0, 1'b1);

        // Start pulse mid-operation and in the FINISH cycle is ignored;
        // the following op starts right away in IDLE.
        runOp(1'b0, 32'h1234_5678, 32'hFEDC_BA98, 10, 1'b1);
        runOp(1'b1, 32'hDEAD_BEEF, 32'h0000_1234, 0,  1'b0);

        // Reset in cycle 15 aborts the operation
        applyStimulus(1'b1, 32'h7FFF_FFFF, 32'd3);
        for (int c = 1; c < 15; c++) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_done", done, 0);
        checkOutput("abort_hi",   hi,   0);
        checkOutput("abort_lo",   lo,   0);
        exp_hi = '0;
        exp_lo = '0;
        bad = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (done !== 1'b0 || hilo_write !== 1'b0 || busy !== 1'b0) bad = 1'b1;
            step();
        end
        checkOutput("abort_quiet", bad, 0);

        // Start coinciding with reset is ignored
        reset = 1'b1;
        start = 1'b1;
        op    = 1'b0;
        a     = 32'd9;
        b     = 32'd9;
        step();
        reset = 1'b0;
        start = 1'b0;
        checkOutput("rststart_busy0", busy, 0);
        step();
        checkOutput("rststart_busy1", busy, 0);

        runOp(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);

        // Randomised operations with a bias toward small and zero divisors
        for (int i = 0; i < 24; i++) begin
            ro = 1'($urandom);
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 3))
                0: rb = $urandom_range(0, 15);
                1: rb = 32'hFFFF_FFFF - $urandom_range(0, 15);
                default: ;
            endcase
            if ($urandom_range(0, 5) == 0) ra = 32'h8000_0000;
            runOp(ro, ra, rb, (i % 3 == 0) ? int'($urandom_range(1, 32)) : 0, (i % 4 == 1));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
